// File: rtl/ddr_rd_arb_pkg.sv
// Shared types and constants for the DDR read-port arbiter.
package ddr_rd_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StBurst = 2'b01,
    StDone  = 2'b10
  } state_e;

  localparam int unsigned LEN_WIDTH = 16;

  function automatic int unsigned bytes_per_word(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr, with wrap.
module rr_pick #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    cand    = '0;
    // Scan from the farthest offset inward so the nearest request to rr_ptr wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'((32'(rr_ptr) + 32'(i)) % NUM_REQ);
      if (req[cand]) begin
        grant   = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// Round-robin burst arbiter sharing one DDR read port between NUM_REQ loaders.
// Optional burst watchdog enabled by defining DDR_RD_ARB_TIMEOUT_EN.
module ddr_rd_arbiter
  import ddr_rd_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_last,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          busy,
  output logic                          ddr_rd_req,
  output logic [ADDR_WIDTH-1:0]         ddr_rd_addr,
  input  logic                          ddr_rd_valid,
  input  logic [DATA_WIDTH-1:0]         ddr_rd_data,
  output logic                          timeout_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_WIDTH-1:0] Step = ADDR_WIDTH'(bytes_per_word(DATA_WIDTH));

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;
  logic [NUM_REQ-1:0]      req_masked;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]    sel_len;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic                    rsp_last_q, rsp_last_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    busy_q, busy_d;
  logic                    ddr_req_q, ddr_req_d;

`ifdef DDR_RD_ARB_TIMEOUT_EN
  localparam logic [LEN_WIDTH-1:0] TimeoutLim = LEN_WIDTH'(TIMEOUT_CYCLES);
  logic [LEN_WIDTH-1:0] wdog_q, wdog_d;
  logic                 tmo_q, tmo_d;
`endif

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (32'(g) == NUM_REQ - 1) ? '0 : g + 1'b1;
  endfunction

  // A requester still sees its ready pulse this cycle and may hold valid; don't regrant it.
  assign req_masked = req_valid & ~req_ready_q;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req    (req_masked),
    .rr_ptr (rr_ptr_q),
    .grant  (pick_idx),
    .any_req(pick_any)
  );

  assign sel_addr = req_addr[32'(pick_idx) * ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_len  = req_len[32'(pick_idx) * LEN_WIDTH +: LEN_WIDTH];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_last_d  = 1'b0;
    rsp_data_d  = rsp_data_q;
    busy_d      = busy_q;
    ddr_req_d   = ddr_req_q;
`ifdef DDR_RD_ARB_TIMEOUT_EN
    wdog_d      = '0;
    tmo_d       = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (pick_any) begin
          grant_d               = pick_idx;
          len_d                 = sel_len;
          cnt_d                 = '0;
          req_ready_d[pick_idx] = 1'b1;
          if (sel_len != '0) begin
            ddr_req_d = 1'b1;
            addr_d    = sel_addr;
            busy_d    = 1'b1;
            state_d   = StBurst;
          end else begin
            rr_ptr_d = next_ptr(pick_idx);
          end
        end
      end
      StBurst: begin
        if (ddr_rd_valid) begin
          rsp_data_d           = ddr_rd_data;
          rsp_valid_d[grant_q] = 1'b1;
          addr_d               = addr_q + Step;
          cnt_d                = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            rsp_last_d = 1'b1;
            ddr_req_d  = 1'b0;
            state_d    = StDone;
          end
        end
`ifdef DDR_RD_ARB_TIMEOUT_EN
        else if (wdog_q + 1'b1 == TimeoutLim) begin
          ddr_req_d  = 1'b0;
          tmo_d      = 1'b1;
          rsp_last_d = 1'b1;
          state_d    = StDone;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
`endif
      end
      StDone: begin
        busy_d   = 1'b0;
        rr_ptr_d = next_ptr(grant_q);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
      ddr_req_q   <= 1'b0;
`ifdef DDR_RD_ARB_TIMEOUT_EN
      wdog_q      <= '0;
      tmo_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      ddr_req_q   <= ddr_req_d;
`ifdef DDR_RD_ARB_TIMEOUT_EN
      wdog_q      <= wdog_d;
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_last    = rsp_last_q;
  assign rsp_data    = rsp_data_q;
  assign busy        = busy_q;
  assign ddr_rd_req  = ddr_req_q;
  assign ddr_rd_addr = addr_q;
`ifdef DDR_RD_ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// Self-checking bench for ddr_rd_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_ddr_rd_arbiter;

  localparam int NR = 3;
  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
  } desc_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*16-1:0]  req_len;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_last;
  logic [DW-1:0]     rsp_data;
  logic              busy;
  logic              ddr_rd_req;
  logic [AW-1:0]     ddr_rd_addr;
  logic              ddr_rd_valid;
  logic [DW-1:0]     ddr_rd_data;
  logic              timeout_err;

  int passed = 0;
  int total  = 0;

  desc_t       dq [NR][$];
  desc_t       mq [NR][$];
  int          grant_log[$];
  beat_t       beat_log[$];
  logic [31:0] addr_log[$];
  int          exp_grant[$];
  beat_t       exp_beat[$];
  logic [31:0] exp_addr[$];
  int          model_ptr = 0;
  int          ddr_mode = 0;
  int          multi_hot = 0, abort_cnt = 0, req_cycles = 0, tmo_cnt = 0;
  int          cyc = 0, last_beat_cyc = 0, tmo_gap = 0;

  ddr_rd_arbiter #(
    .NUM_REQ       (NR),
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_last    (rsp_last),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .ddr_rd_req  (ddr_rd_req),
    .ddr_rd_addr (ddr_rd_addr),
    .ddr_rd_valid(ddr_rd_valid),
    .ddr_rd_data (ddr_rd_data),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'h5A5A_0F0F, ~a};
  endfunction

  // Requesters: present the head descriptor, retire it on the ready pulse.
  initial begin : req_drv
    req_valid = '0;
    req_addr  = '0;
    req_len   = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (reset && req_ready[i] && dq[i].size() > 0) void'(dq[i].pop_front());
        if (dq[i].size() > 0) begin
          req_valid[i]          = 1'b1;
          req_addr[i*AW +: AW]  = dq[i][0].addr;
          req_len[i*16 +: 16]   = dq[i][0].len;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  // DDR memory model; mode picks the valid pattern while a request is open.
  initial begin : ddr_drv
    int   gap;
    logic v;
    gap          = 0;
    ddr_rd_valid = 1'b0;
    ddr_rd_data  = '0;
    forever begin
      @(negedge clk);
      v = 1'b0;
      if (!reset || !ddr_rd_req) begin
        gap = 0;
      end else begin
        gap++;
        case (ddr_mode)
          0:       v = 1'b1;
          1:       v = ($urandom_range(0, 2) != 0);
          2:       v = (gap == 1 || gap == 4 || gap == 9);
          default: v = (gap == 1);
        endcase
      end
      ddr_rd_valid = v;
      ddr_rd_data  = v ? mem_word(ddr_rd_addr) : {$urandom, $urandom};
      if (v) addr_log.push_back(ddr_rd_addr);
    end
  end

  initial begin : mon
    beat_t b;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        for (int i = 0; i < NR; i++) if (req_ready[i]) grant_log.push_back(i);
        if ($countones(rsp_valid) > 1) multi_hot++;
        for (int i = 0; i < NR; i++) begin
          if (rsp_valid[i]) begin
            b.idx  = 3'(i);
            b.data = rsp_data;
            b.last = rsp_last;
            beat_log.push_back(b);
            last_beat_cyc = cyc;
          end
        end
        if (rsp_last && rsp_valid == '0) abort_cnt++;
        if (ddr_rd_req) req_cycles++;
        if (timeout_err) begin
          tmo_cnt++;
          tmo_gap = cyc - last_beat_cyc;
        end
      end
    end
  end

  task automatic clear_logs();
    grant_log.delete();
    beat_log.delete();
    addr_log.delete();
    multi_hot  = 0;
    abort_cnt  = 0;
    req_cycles = 0;
    tmo_cnt    = 0;
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [15:0] l);
    desc_t d;
    d.addr = a;
    d.len  = l;
    dq[i].push_back(d);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < NR; i++) dq[i].delete();
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    model_ptr = 0;
    clear_logs();
  endtask

  task automatic wait_done(input int budget, input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (dq[0].size() == 0 && dq[1].size() == 0 && dq[2].size() == 0 && !busy &&
          !ddr_rd_req && req_valid == '0 && req_ready == '0) quiet++;
      else quiet = 0;
    end
    total++;
    if (quiet < 3) $display("FAIL %s_idle: still active after %0d cycles, want idle", name, n);
    else passed++;
  endtask

  // Transaction-level round robin over the loaded queues.
  task automatic model_run();
    int          g, c;
    desc_t       d;
    beat_t       b;
    logic [31:0] a;
    exp_grant.delete();
    exp_beat.delete();
    exp_addr.delete();
    for (int i = 0; i < NR; i++) mq[i] = dq[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        c = (model_ptr + k) % NR;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g < 0) break;
      d = mq[g].pop_front();
      exp_grant.push_back(g);
      for (int k = 0; k < int'(d.len); k++) begin
        a      = d.addr + 32'(k * 8);
        b.idx  = 3'(g);
        b.data = mem_word(a);
        b.last = (k == int'(d.len) - 1);
        exp_addr.push_back(a);
        exp_beat.push_back(b);
      end
      model_ptr = (g + 1) % NR;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_last, rsp_data, busy, ddr_rd_req, ddr_rd_addr,
         timeout_err} !== '0) $display("FAIL reset_hold: outputs nonzero during reset");
    else passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({req_ready, rsp_valid, rsp_last, rsp_data, busy, ddr_rd_req, ddr_rd_addr,
         timeout_err} !== '0) $display("FAIL reset_release: outputs nonzero with no requests");
    else passed++;
  endtask

  task automatic test_contention();
    int          exp_g[4]    = '{0, 1, 2, 0};
    logic [31:0] exp_base[4] = '{32'h100, 32'h200, 32'h300, 32'h400};
    logic [31:0] a;
    clear_logs();
    ddr_mode = 0;
    @(posedge clk);
    load(0, 32'h100, 16'd2);
    load(0, 32'h400, 16'd2);
    load(1, 32'h200, 16'd2);
    load(2, 32'h300, 16'd2);
    wait_done(200, "contention");
    total++;
    if (grant_log.size() != 4) $display("FAIL cont_grants: got %0d pulses, want 4", grant_log.size());
    else passed++;
    for (int k = 0; k < 4 && k < grant_log.size(); k++) begin
      total++;
      if (grant_log[k] !== exp_g[k])
        $display("FAIL cont_order[%0d]: got %0d, want %0d", k, grant_log[k], exp_g[k]);
      else passed++;
    end
    total++;
    if (beat_log.size() != 8) $display("FAIL cont_beats: got %0d, want 8", beat_log.size());
    else passed++;
    for (int k = 0; k < 8 && k < beat_log.size(); k++) begin
      a = exp_base[k/2] + 32'((k % 2) * 8);
      total++;
      if (int'(beat_log[k].idx) != exp_g[k/2] || beat_log[k].data !== mem_word(a) ||
          beat_log[k].last !== (k % 2 == 1))
        $display("FAIL cont_beat[%0d]: got idx=%0d data=%h last=%0b, want idx=%0d data=%h last=%0b",
                 k, beat_log[k].idx, beat_log[k].data, beat_log[k].last, exp_g[k/2],
                 mem_word(a), (k % 2 == 1));
      else passed++;
    end
    total++;
    if (multi_hot != 0) $display("FAIL cont_onehot: got %0d multi-hot cycles, want 0", multi_hot);
    else passed++;
  endtask

  task automatic test_single();
    clear_logs();
    ddr_mode = 0;
    @(posedge clk);
    load(1, 32'h1000, 16'd4);
    wait_done(100, "single");
    total++;
    if (grant_log.size() != 1 || grant_log[0] != 1)
      $display("FAIL single_grant: got %0d pulses, want one for requester 1", grant_log.size());
    else passed++;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (k >= addr_log.size() || addr_log[k] !== 32'h1000 + 32'(8 * k))
        $display("FAIL single_addr[%0d]: got %h, want %h", k,
                 (k < addr_log.size()) ? addr_log[k] : 32'hx, 32'h1000 + 32'(8 * k));
      else passed++;
      total++;
      if (k >= beat_log.size() || beat_log[k].idx !== 3'd1 ||
          beat_log[k].data !== mem_word(32'h1000 + 32'(8 * k)) || beat_log[k].last !== (k == 3))
        $display("FAIL single_beat[%0d]: missing or wrong (have %0d beats), want idx=1 last=%0b",
                 k, beat_log.size(), (k == 3));
      else passed++;
    end
    total++;
    if (beat_log.size() != 4 || req_cycles != 4)
      $display("FAIL single_len: got %0d beats, %0d req cycles, want 4 and 4",
               beat_log.size(), req_cycles);
    else passed++;
  endtask

  task automatic test_zero_len();
    clear_logs();
    ddr_mode = 0;
    @(posedge clk);
    load(2, 32'h8000, 16'd0);
    wait_done(50, "zero_len");
    total++;
    if (grant_log.size() != 1 || grant_log[0] != 2 || req_cycles != 0 || beat_log.size() != 0)
      $display("FAIL zero_len: got %0d pulses, %0d req cycles, %0d beats, want 1, 0, 0",
               grant_log.size(), req_cycles, beat_log.size());
    else passed++;
    clear_logs();
    @(posedge clk);
    load(1, 32'h9100, 16'd1);
    load(0, 32'h9000, 16'd1);
    wait_done(50, "zero_next");
    total++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1)
      $display("FAIL zero_next_order: got %0d grants first=%0d, want order 0,1",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : -1);
    else passed++;
  endtask

  task automatic test_gappy();
    clear_logs();
    ddr_mode = 2;
    @(posedge clk);
    load(0, 32'h2000, 16'd3);
    wait_done(100, "gappy");
    total++;
    if (beat_log.size() != 3 || req_cycles != 9)
      $display("FAIL gappy_len: got %0d beats, %0d req cycles, want 3 and 9",
               beat_log.size(), req_cycles);
    else passed++;
    for (int k = 0; k < 3 && k < beat_log.size() && k < addr_log.size(); k++) begin
      total++;
      if (addr_log[k] !== 32'h2000 + 32'(8 * k) || beat_log[k].last !== (k == 2) ||
          beat_log[k].data !== mem_word(32'h2000 + 32'(8 * k)))
        $display("FAIL gappy_beat[%0d]: got addr=%h last=%0b, want addr=%h last=%0b",
                 k, addr_log[k], beat_log[k].last, 32'h2000 + 32'(8 * k), (k == 2));
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    ddr_mode = 0;
    @(posedge clk);
    load(0, 32'hA000, 16'd8);
    while (beat_log.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (beat_log.size() < 2) $display("FAIL rst_mid_start: got %0d beats, want 2", beat_log.size());
    else passed++;
    #2 reset = 1'b0;
    for (int i = 0; i < NR; i++) dq[i].delete();
    #1;
    total++;
    if ({req_ready, rsp_valid, rsp_last, rsp_data, busy, ddr_rd_req, ddr_rd_addr,
         timeout_err} !== '0) $display("FAIL rst_mid_clear: outputs nonzero under reset");
    else passed++;
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    model_ptr = 0;
    clear_logs();
    @(posedge clk);
    load(0, 32'hB000, 16'd2);
    wait_done(100, "rst_mid");
    total++;
    if (grant_log.size() != 1 || grant_log[0] != 0 || beat_log.size() != 2 ||
        beat_log[1].data !== mem_word(32'hB008) || beat_log[1].last !== 1'b1)
      $display("FAIL rst_mid_regrant: got %0d grants %0d beats, want 1 grant of 0 and 2 beats",
               grant_log.size(), beat_log.size());
    else passed++;
  endtask

  task automatic test_random();
    int n;
    apply_reset();
    ddr_mode = 1;
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      @(posedge clk);
      for (int i = 0; i < NR; i++) begin
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++)
          load(i, ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 : ($urandom & ~32'h7),
               16'($urandom_range(0, 6)));
      end
      model_run();
      wait_done(800, "random");
      total++;
      if (grant_log.size() != exp_grant.size() || beat_log.size() != exp_beat.size() ||
          addr_log.size() != exp_addr.size())
        $display("FAIL rand_sizes[%0d]: got g=%0d b=%0d a=%0d, want g=%0d b=%0d a=%0d", r,
                 grant_log.size(), beat_log.size(), addr_log.size(), exp_grant.size(),
                 exp_beat.size(), exp_addr.size());
      else passed++;
      for (int k = 0; k < exp_grant.size() && k < grant_log.size(); k++) begin
        total++;
        if (grant_log[k] != exp_grant[k])
          $display("FAIL rand_grant[%0d.%0d]: got %0d, want %0d", r, k, grant_log[k], exp_grant[k]);
        else passed++;
      end
      for (int k = 0; k < exp_beat.size() && k < beat_log.size() && k < addr_log.size(); k++) begin
        total++;
        if (beat_log[k] !== exp_beat[k] || addr_log[k] !== exp_addr[k])
          $display("FAIL rand_beat[%0d.%0d]: got idx=%0d data=%h last=%0b addr=%h, want idx=%0d data=%h last=%0b addr=%h",
                   r, k, beat_log[k].idx, beat_log[k].data, beat_log[k].last, addr_log[k],
                   exp_beat[k].idx, exp_beat[k].data, exp_beat[k].last, exp_addr[k]);
        else passed++;
      end
      total++;
      if (multi_hot != 0 || abort_cnt != 0 || tmo_cnt != 0)
        $display("FAIL rand_misc[%0d]: got multi_hot=%0d aborts=%0d timeouts=%0d, want 0 0 0", r,
                 multi_hot, abort_cnt, tmo_cnt);
      else passed++;
    end
  endtask

`ifdef DDR_RD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    ddr_mode = 3;
    @(posedge clk);
    load(0, 32'hC000, 16'd4);
    load(1, 32'hD000, 16'd1);
    wait_done(200, "timeout");
    total++;
    if (tmo_cnt != 1 || tmo_gap != 16 || abort_cnt != 1)
      $display("FAIL tmo_pulse: got count=%0d gap=%0d aborts=%0d, want 1 16 1",
               tmo_cnt, tmo_gap, abort_cnt);
    else passed++;
    total++;
    if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 1 ||
        beat_log.size() != 2 || beat_log[0].last !== 1'b0 || beat_log[1].idx !== 3'd1 ||
        beat_log[1].last !== 1'b1)
      $display("FAIL tmo_recover: got %0d grants %0d beats, want grants 0,1 and 2 beats",
               grant_log.size(), beat_log.size());
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_zero_len();
    test_gappy();
    test_reset_mid();
    test_random();
`ifdef DDR_RD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
